display_framebuffer_pwm: RTL

- Double-buffered RGB frame buffer with a per-channel PWM comparator.
- Sits directly upstream of the display driver FSM and consumes its row, column, cycle and safe_flip outputs.
- Drives the panel R/G/B data bits that the driver clocks out with oclk/lat.
- Host logic writes pixels into the back buffer and requests a flip; the swap happens only in the driver's safe_flip window.

---
 rtl/display_framebuffer_pwm.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/display_framebuffer_pwm.sv
// Purpose : double-buffered RGB frame buffer feeding a per-channel PWM comparator for the panel driver.
// Latency : 2 clk from row/column/cycle to r/g/b; writes land in 1 clk; a flip completes on the first safe_flip after it is accepted.
// Backpr. : none; writes are always accepted, and flip_req while a flip is pending is dropped (no queueing).
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_row, i_column, i_cycle       scan position and PWM cycle from the display driver
//   i_safe_flip                    end-of-frame pulse from the driver; the only point where banks may swap
//   i_wr_en, i_wr_row, i_wr_column, i_wr_data   back-buffer pixel write, data is {R,G,B} with R in the MSBs
//   i_flip_req                     one-cycle request to swap front and back banks
//   o_flip_pending, o_flip_done    flip accepted / swap happened this clock
//   o_r, o_g, o_b                  panel data bits
//
// Build option: define DISPLAY_FB_GAMMA_EN to pass every written channel through a
// constant gamma-2.2 lookup before it is stored. Without it, pixels are stored unchanged.
module display_framebuffer_pwm #(
    parameter int ROWS     = 8,
    parameter int COLUMNS  = 32,
    parameter int BITDEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [$clog2(ROWS)-1:0]    i_row,
    input  logic [$clog2(COLUMNS)-1:0] i_column,
    input  logic [BITDEPTH-1:0]        i_cycle,
    input  logic                       i_safe_flip,
    input  logic                       i_wr_en,
    input  logic [$clog2(ROWS)-1:0]    i_wr_row,
    input  logic [$clog2(COLUMNS)-1:0] i_wr_column,
    input  logic [3*BITDEPTH-1:0]      i_wr_data,
    input  logic                       i_flip_req,
    output logic                       o_flip_pending,
    output logic                       o_flip_done,
    output logic                       o_r,
    output logic                       o_g,
    output logic                       o_b
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLUMNS);
    localparam int AW = 1 + RW + CW;
    localparam int DW = 3 * BITDEPTH;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } state_t;

    state_t                r_state;
    logic                  r_sel;
    logic                  r_flip_pending;
    logic                  r_flip_done;

    logic [DW-1:0]         r_mem [0:(1<<AW)-1];
    logic [DW-1:0]         r_rd_dat;
    logic [BITDEPTH-1:0]   r_cycle_d;
    logic                  r_out_r;
    logic                  r_out_g;
    logic                  r_out_b;

    logic                  w_wr_ok;
    logic [AW-1:0]         w_wr_addr;
    logic [AW-1:0]         w_rd_addr;
    logic [DW-1:0]         w_wr_dat;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
`ifdef DISPLAY_FB_GAMMA_EN
    localparam int MAXV = (1 << BITDEPTH) - 1;

    // Elaboration-time only: builds the constant gamma-2.2 table.
    function automatic logic [BITDEPTH-1:0] f_gamma(input int v);
        real x;
        real y;
        x = real'(v) / real'(MAXV);
        y = real'(MAXV) * (x ** 2.2);
        return BITDEPTH'($rtoi(y + 0.5));
    endfunction

    logic [BITDEPTH-1:0] w_gamma_rom [0:MAXV];

    for (genvar gi = 0; gi <= MAXV; gi++) begin : g_gamma_rom
        assign w_gamma_rom[gi] = f_gamma(gi);
    end

    assign w_wr_dat = {w_gamma_rom[i_wr_data[3*BITDEPTH-1:2*BITDEPTH]],
                       w_gamma_rom[i_wr_data[2*BITDEPTH-1:BITDEPTH]],
                       w_gamma_rom[i_wr_data[BITDEPTH-1:0]]};
`else
    assign w_wr_dat = i_wr_data;
`endif

    // Widen by one bit so the bound check stays meaningful when ROWS/COLUMNS
    // are not powers of two and does not collapse to a constant when they are.
    assign w_wr_ok   = i_wr_en
                     && ({1'b0, i_wr_row}    < (RW + 1)'(ROWS))
                     && ({1'b0, i_wr_column} < (CW + 1)'(COLUMNS));

    // Writes always target the bank that is not being displayed. On the swap
    // clock r_sel still holds the old value, so that write lands in the bank
    // about to become front.
    assign w_wr_addr = {~r_sel, i_wr_row, i_wr_column};
    assign w_rd_addr = { r_sel, i_row,    i_column};

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_addr] <= w_wr_dat;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: stage 1 memory read + cycle delay, stage 2 compare
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_dat  <= '0;
            r_cycle_d <= '0;
            r_out_r   <= 1'b0;
            r_out_g   <= 1'b0;
            r_out_b   <= 1'b0;
        end else begin
            r_rd_dat  <= r_mem[w_rd_addr];
            r_cycle_d <= i_cycle;
            // Strict greater-than: value 0 never lights, full scale is dark
            // only on the last cycle of the PWM period.
            r_out_r   <= r_rd_dat[3*BITDEPTH-1:2*BITDEPTH] > r_cycle_d;
            r_out_g   <= r_rd_dat[2*BITDEPTH-1:BITDEPTH]   > r_cycle_d;
            r_out_b   <= r_rd_dat[BITDEPTH-1:0]            > r_cycle_d;
        end
    end

    // ------------------------------------------------------------------
    // Flip state machine
    // ------------------------------------------------------------------
    // A safe_flip arriving in IDLE is ignored even when flip_req is high on
    // the same clock: the request is only captured, and the swap waits for
    // the next frame boundary.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_sel          <= 1'b0;
            r_flip_pending <= 1'b0;
            r_flip_done    <= 1'b0;
        end else begin
            r_flip_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_flip_req) begin
                        r_state        <= ST_PENDING;
                        r_flip_pending <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (i_safe_flip) begin
                        r_state        <= ST_IDLE;
                        r_flip_pending <= 1'b0;
                        r_sel          <= ~r_sel;
                        r_flip_done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_flip_pending = r_flip_pending;
    assign o_flip_done    = r_flip_done;
    assign o_r            = r_out_r;
    assign o_g            = r_out_g;
    assign o_b            = r_out_b;

endmodule
